pcm_to_i2s: RTL and testbench
=============================

PCM_TO_I2S -- requirements
Module: pcm_to_i2s

Interface
REQ-001 Parameter NUMBER_OF_BITS, default 16, PCM sample width per channel.
REQ-002 Parameter SLOT_BITS, default 32, SCK periods per channel slot; SHALL be >= NUMBER_OF_BITS+1.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  1 = generate I2S bus, 0 = bus idle.
REQ-006 s_valid  input  1  stereo sample offered.
REQ-007 s_left  input  NUMBER_OF_BITS  left PCM sample, two's complement.
REQ-008 s_right  input  NUMBER_OF_BITS  right PCM sample, two's complement.
REQ-009 s_ready  output  1  sample FIFO can accept a sample.
REQ-010 sck  output  1  I2S bit clock, clk/2.
REQ-011 ws  output  1  word select, 0 = left slot, 1 = right slot.
REQ-012 sd  output  1  I2S serial data, MSB first.
REQ-013 underflow  output  1  one-clk pulse: frame started with empty FIFO.

Function
REQ-014 2-entry FIFO of {s_left,s_right}; push on s_valid && s_ready; s_ready = FIFO not full, registered count.
REQ-015 enable=1: sck toggles every clk; sck 1->0 transitions = "falling events"; ws/sd change only on falling events, so they are stable at every sck rise.
REQ-016 Bit counter 0..2*SLOT_BITS-1, advances on each falling event, wraps 2*SLOT_BITS-1 -> 0.
REQ-017 ws = 0 for counter 0..SLOT_BITS-1, 1 for SLOT_BITS..2*SLOT_BITS-1.
REQ-018 Slot position p (counter mod SLOT_BITS): p=0 -> sd=0; p=1..NUMBER_OF_BITS -> sample bits MSB..LSB; p>NUMBER_OF_BITS -> sd=0.
REQ-019 On wrap to counter 0: pop FIFO head into left/right shift registers; pop and push in same clk both take effect; pop sees pre-push contents.
REQ-020 Wrap with empty FIFO: underflow=1 for that clk, frame transmits zeros (see REQ-027).
REQ-021 enable 1->0: next clk sck=0, ws=0, sd=0, counter=2*SLOT_BITS-1, in-flight frame discarded, FIFO retained, pushes still accepted.
REQ-022 enable 0->1: first clk sck=1; next clk first falling event, counter=0, frame load per REQ-019/020.
REQ-023 Sample accepted into empty FIFO while idle: left MSB on sd at falling event counter=1, i.e. 4 clk after enable rise.

Reset
REQ-024 rst_n low: immediately sck=0, ws=0, sd=0, underflow=0, FIFO empty, shift registers 0, counter=2*SLOT_BITS-1.
REQ-025 s_ready SHALL be 0 while rst_n low; 1 from first clk after release.
REQ-026 Reset mid-frame aborts frame; no partial bits after release until enable restarts per REQ-022.

Configuration
REQ-027 Macro PCM_TO_I2S_UNDERFLOW_REPEAT_EN: defined -> underflow frame retransmits last popped sample (0 if none since reset); undefined -> underflow frame all zeros; underflow pulse identical in both.

Verification (NUMBER_OF_BITS=16, SLOT_BITS=32)
REQ-028 Push L=0xA5F0, R=0x0F0F, enable=1 -> at sck rises: ws=0 x32 with sd 0,A5F0 MSB-first,15 zeros; then ws=1 x32 with sd 0,0F0F,15 zeros; sck period 2 clk.
REQ-029 enable=0, push 3 samples back-to-back -> first two accepted, s_ready=0 on third; one pop -> s_ready=1 next clk.
REQ-030 enable=1, FIFO empty -> underflow pulse every 128 clk, sd=0; with PCM_TO_I2S_UNDERFLOW_REPEAT_EN after one 0x1234/0x8001 frame -> same pattern repeats.
REQ-031 rst_n low at counter=10 -> sck/ws/sd 0 same cycle, FIFO empty; release + enable -> frame from counter 0 with underflow pulse.
REQ-032 enable dropped at counter=40 with 1 sample queued -> bus idle next clk; re-enable -> queued sample sent from counter 0, ws=0 first.
REQ-033 Push into empty FIFO on the wrap clk -> underflow pulses, sample sent in next frame.

Source files
------------

// File: rtl/pcm_to_i2s.sv
// PCM-to-I2S serializer: 2-entry stereo sample FIFO feeding an I2S master (sck = clk/2).
// Define PCM_TO_I2S_UNDERFLOW_REPEAT_EN to resend the last popped sample on underflow instead of zeros.
module pcm_to_i2s #(
  parameter int NUMBER_OF_BITS = 16,
  parameter int SLOT_BITS      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      s_valid,
  input  logic [NUMBER_OF_BITS-1:0] s_left,
  input  logic [NUMBER_OF_BITS-1:0] s_right,
  output logic                      s_ready,
  output logic                      sck,
  output logic                      ws,
  output logic                      sd,
  output logic                      underflow
);

  localparam int              CW   = $clog2(2 * SLOT_BITS);
  localparam int              W    = 2 * NUMBER_OF_BITS;
  localparam logic [CW-1:0]   LAST = CW'(2 * SLOT_BITS - 1);
  localparam logic [CW-1:0]   SLOT = CW'(SLOT_BITS);
  localparam logic [CW-1:0]   NB   = CW'(NUMBER_OF_BITS);

  logic [W-1:0]              r_mem [2];
  logic                      r_wptr;
  logic                      r_rptr;
  logic [1:0]                r_count;
  logic                      r_ready;
  logic                      r_sck;
  logic                      r_ws;
  logic                      r_sd;
  logic                      r_underflow;
  logic [CW-1:0]             r_cnt;
  logic [NUMBER_OF_BITS-1:0] r_sh_l;
  logic [NUMBER_OF_BITS-1:0] r_sh_r;

  logic                      w_push;
  logic                      w_fall;
  logic                      w_wrap;
  logic                      w_pop;
  logic                      w_empty_wrap;
  logic [1:0]                w_count_nxt;
  logic [CW-1:0]             w_cnt_nxt;
  logic                      w_ws_nxt;
  logic [CW-1:0]             w_pos;
  logic                      w_data_pos;
  logic [W-1:0]              w_fill;
  logic [W-1:0]              w_load;

  assign w_push       = s_valid && r_ready;
  assign w_fall       = enable && r_sck;
  assign w_wrap       = w_fall && (r_cnt == LAST);
  assign w_pop        = w_wrap && (r_count != 2'd0);
  assign w_empty_wrap = w_wrap && (r_count == 2'd0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_cnt_nxt  = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    w_ws_nxt   = (w_cnt_nxt >= SLOT);
    w_pos      = w_ws_nxt ? (w_cnt_nxt - SLOT) : w_cnt_nxt;
    w_data_pos = (w_pos != '0) && (w_pos <= NB);
  end

`ifdef PCM_TO_I2S_UNDERFLOW_REPEAT_EN
  logic [W-1:0] r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
    end else if (w_pop) begin
      r_last <= r_mem[r_rptr];
    end
  end

  assign w_fill = r_last;
`else
  assign w_fill = '0;
`endif

  assign w_load = w_pop ? r_mem[r_rptr] : w_fill;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {s_left, s_right};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
      r_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

  // ws/sd are only updated on the sck 1->0 edge so they are settled at every sck rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck       <= 1'b0;
      r_ws        <= 1'b0;
      r_sd        <= 1'b0;
      r_cnt       <= LAST;
      r_sh_l      <= '0;
      r_sh_r      <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= w_empty_wrap;
      if (!enable) begin
        r_sck <= 1'b0;
        r_ws  <= 1'b0;
        r_sd  <= 1'b0;
        r_cnt <= LAST;
      end else begin
        r_sck <= ~r_sck;
        if (r_sck) begin
          r_cnt <= w_cnt_nxt;
          r_ws  <= w_ws_nxt;
          r_sd  <= 1'b0;
          if (w_wrap) begin
            r_sh_l <= w_load[W-1:NUMBER_OF_BITS];
            r_sh_r <= w_load[NUMBER_OF_BITS-1:0];
          end else if (w_data_pos) begin
            if (!w_ws_nxt) begin
              r_sd   <= r_sh_l[NUMBER_OF_BITS-1];
              r_sh_l <= r_sh_l << 1;
            end else begin
              r_sd   <= r_sh_r[NUMBER_OF_BITS-1];
              r_sh_r <= r_sh_r << 1;
            end
          end
        end
      end
    end
  end

  assign s_ready   = r_ready;
  assign sck       = r_sck;
  assign ws        = r_ws;
  assign sd        = r_sd;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_pcm_to_i2s.sv
// Directed self-checking bench for pcm_to_i2s (16-bit samples, 32-bit slots).
module tb_pcm_to_i2s;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        s_valid;
  logic [15:0] s_left;
  logic [15:0] s_right;
  logic        s_ready;
  logic        sck;
  logic        ws;
  logic        sd;
  logic        underflow;

  int n_pass  = 0;
  int n_total = 0;

  pcm_to_i2s #(.NUMBER_OF_BITS(16), .SLOT_BITS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .s_valid   (s_valid),
    .s_left    (s_left),
    .s_right   (s_right),
    .s_ready   (s_ready),
    .sck       (sck),
    .ws        (ws),
    .sd        (sd),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n   = 1'b0;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_left  = '0;
    s_right = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Records one frame (64 sck rises); skip=1 discards the rise that precedes the first falling event.
  task automatic capture_frame(input int skip, output logic [15:0] l, output logic [15:0] r,
                               output int bad, output int uf);
    int   rises = 0;
    int   cyc   = 0;
    int   last  = 0;
    int   k;
    int   p;
    logic prev;
    l = '0; r = '0; bad = 0; uf = 0;
    prev = sck;
    while (rises < 64 + skip && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (underflow === 1'b1) uf++;
      if (sck === 1'b1 && prev === 1'b0) begin
        if (rises >= skip) begin
          k = rises - skip;
          p = k % 32;
          if (ws !== (k >= 32)) bad++;
          if (p >= 1 && p <= 16) begin
            if (k < 32) l[16-p] = sd;
            else        r[16-p] = sd;
          end else if (sd !== 1'b0) begin
            bad++;
          end
          if (k > 0 && cyc - last != 2) bad++;
        end
        last = cyc;
        rises++;
      end
      prev = sck;
    end
    if (rises < 64 + skip) bad += 1000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;
    #1;
    n_total++; if ({sck, ws, sd, underflow} !== 4'b0000) $display("FAIL reset_bus: got %b required 0000", {sck, ws, sd, underflow}); else n_pass++;
    n_total++; if (s_ready !== 1'b0) $display("FAIL reset_ready_low: got %b required 0", s_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (s_ready !== 1'b1) $display("FAIL reset_ready_release: got %b required 1", s_ready); else n_pass++;
    n_total++; if ({sck, ws, sd} !== 3'b000) $display("FAIL reset_idle: got %b required 000", {sck, ws, sd}); else n_pass++;
  endtask

  task automatic test_frame();
    logic [15:0] l, r;
    int          bad, uf, n, sd_ones, ws_ones;
    bit          found;
    do_reset();
    push(16'hA5F0, 16'h0F0F);
    enable = 1'b1;
    capture_frame(1, l, r, bad, uf);
    n_total++; if (l !== 16'hA5F0) $display("FAIL frame_left: got %h required a5f0", l); else n_pass++;
    n_total++; if (r !== 16'h0F0F) $display("FAIL frame_right: got %h required 0f0f", r); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL frame_shape: got %0d errors required 0", bad); else n_pass++;
    n_total++; if (uf !== 0) $display("FAIL frame_no_underflow: got %0d pulses required 0", uf); else n_pass++;
    capture_frame(0, l, r, bad, uf);
    n_total++; if (uf !== 1) $display("FAIL uf_frame_pulse: got %0d pulses required 1", uf); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL uf_frame_shape: got %0d errors required 0", bad); else n_pass++;
`ifdef PCM_TO_I2S_UNDERFLOW_REPEAT_EN
    n_total++; if ({l, r} !== 32'hA5F0_0F0F) $display("FAIL uf_frame_data: got %h required a5f00f0f", {l, r}); else n_pass++;
`else
    n_total++; if ({l, r} !== 32'h0) $display("FAIL uf_frame_data: got %h required 00000000", {l, r}); else n_pass++;
`endif
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (underflow === 1'b1) found = 1'b1;
    end
    n_total++; if (!found) $display("FAIL uf_seen: got no pulse required pulse"); else n_pass++;
    n = 0; sd_ones = 0; ws_ones = 0;
    do begin
      @(negedge clk);
      n++;
      if (sd === 1'b1) sd_ones++;
      if (ws === 1'b1) ws_ones++;
    end while (underflow !== 1'b1 && n < 300);
    n_total++; if (n !== 128) $display("FAIL uf_period: got %0d clk required 128", n); else n_pass++;
    n_total++; if (ws_ones !== 64) $display("FAIL uf_ws_duty: got %0d clk required 64", ws_ones); else n_pass++;
`ifdef PCM_TO_I2S_UNDERFLOW_REPEAT_EN
    n_total++; if (sd_ones !== 32) $display("FAIL uf_sd_ones: got %0d clk required 32", sd_ones); else n_pass++;
`else
    n_total++; if (sd_ones !== 0) $display("FAIL uf_sd_ones: got %0d clk required 0", sd_ones); else n_pass++;
`endif
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] l, r;
    int          bad, uf;
    do_reset();
    n_total++; if (s_ready !== 1'b1) $display("FAIL b2b_ready0: got %b required 1", s_ready); else n_pass++;
    s_valid = 1'b1; s_left = 16'h1234; s_right = 16'h8001;
    @(negedge clk);
    n_total++; if (s_ready !== 1'b1) $display("FAIL b2b_ready1: got %b required 1", s_ready); else n_pass++;
    s_left = 16'h7FFF; s_right = 16'h8000;
    @(negedge clk);
    n_total++; if (s_ready !== 1'b0) $display("FAIL b2b_ready2: got %b required 0", s_ready); else n_pass++;
    s_left = 16'hDEAD; s_right = 16'hBEEF;
    @(negedge clk);
    s_valid = 1'b0;
    n_total++; if (s_ready !== 1'b0) $display("FAIL b2b_full_hold: got %b required 0", s_ready); else n_pass++;
    enable = 1'b1;
    @(negedge clk);
    n_total++; if (s_ready !== 1'b0) $display("FAIL b2b_before_pop: got %b required 0", s_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (s_ready !== 1'b1) $display("FAIL b2b_after_pop: got %b required 1", s_ready); else n_pass++;
    enable = 1'b0;
    @(negedge clk);
    n_total++; if ({sck, ws, sd} !== 3'b000) $display("FAIL b2b_idle: got %b required 000", {sck, ws, sd}); else n_pass++;
    enable = 1'b1;
    capture_frame(1, l, r, bad, uf);
    n_total++; if ({l, r} !== 32'h7FFF_8000) $display("FAIL b2b_second: got %h required 7fff8000", {l, r}); else n_pass++;
    n_total++; if (bad !== 0 || uf !== 0) $display("FAIL b2b_second_shape: got bad=%0d uf=%0d required 0/0", bad, uf); else n_pass++;
    capture_frame(0, l, r, bad, uf);
    n_total++; if (uf !== 1) $display("FAIL b2b_third_dropped: got %0d pulses required 1", uf); else n_pass++;
`ifdef PCM_TO_I2S_UNDERFLOW_REPEAT_EN
    n_total++; if ({l, r} !== 32'h7FFF_8000) $display("FAIL b2b_uf_data: got %h required 7fff8000", {l, r}); else n_pass++;
`else
    n_total++; if ({l, r} !== 32'h0) $display("FAIL b2b_uf_data: got %h required 00000000", {l, r}); else n_pass++;
`endif
    enable = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [15:0] l, r;
    int          bad, uf;
    do_reset();
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    enable = 1'b1;
    repeat (22) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++; if ({sck, ws, sd} !== 3'b000) $display("FAIL midrst_bus: got %b required 000", {sck, ws, sd}); else n_pass++;
    n_total++; if (s_ready !== 1'b0) $display("FAIL midrst_ready: got %b required 0", s_ready); else n_pass++;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if ({sck, ws, sd} !== 3'b000) $display("FAIL midrst_after: got %b required 000", {sck, ws, sd}); else n_pass++;
    enable = 1'b1;
    capture_frame(1, l, r, bad, uf);
    n_total++; if (uf !== 1) $display("FAIL midrst_uf: got %0d pulses required 1", uf); else n_pass++;
    n_total++; if ({l, r} !== 32'h0) $display("FAIL midrst_data: got %h required 00000000", {l, r}); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL midrst_shape: got %0d errors required 0", bad); else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_enable_drop_and_wrap_push();
    logic [15:0] l, r;
    int          bad, uf;
    do_reset();
    push(16'hAAAA, 16'h5555);
    push(16'hC3C3, 16'h3C3C);
    enable = 1'b1;
    repeat (82) @(negedge clk);
    n_total++; if (ws !== 1'b1) $display("FAIL drop_ws_before: got %b required 1", ws); else n_pass++;
    enable = 1'b0;
    @(negedge clk);
    n_total++; if ({sck, ws, sd} !== 3'b000) $display("FAIL drop_idle: got %b required 000", {sck, ws, sd}); else n_pass++;
    enable = 1'b1;
    capture_frame(1, l, r, bad, uf);
    n_total++; if ({l, r} !== 32'hC3C3_3C3C) $display("FAIL drop_resume: got %h required c3c33c3c", {l, r}); else n_pass++;
    n_total++; if (bad !== 0 || uf !== 0) $display("FAIL drop_resume_shape: got bad=%0d uf=%0d required 0/0", bad, uf); else n_pass++;
    // Now at the last sck rise of the frame: the next clk is the wrap.
    n_total++; if (s_ready !== 1'b1) $display("FAIL wrap_ready: got %b required 1", s_ready); else n_pass++;
    s_valid = 1'b1; s_left = 16'h0F0F; s_right = 16'hF0F0;
    @(negedge clk);
    s_valid = 1'b0;
    n_total++; if (underflow !== 1'b1) $display("FAIL wrap_push_uf: got %b required 1", underflow); else n_pass++;
    capture_frame(0, l, r, bad, uf);
`ifdef PCM_TO_I2S_UNDERFLOW_REPEAT_EN
    n_total++; if ({l, r} !== 32'hC3C3_3C3C) $display("FAIL wrap_uf_data: got %h required c3c33c3c", {l, r}); else n_pass++;
`else
    n_total++; if ({l, r} !== 32'h0) $display("FAIL wrap_uf_data: got %h required 00000000", {l, r}); else n_pass++;
`endif
    capture_frame(0, l, r, bad, uf);
    n_total++; if ({l, r} !== 32'h0F0F_F0F0) $display("FAIL wrap_next_data: got %h required 0f0ff0f0", {l, r}); else n_pass++;
    n_total++; if (bad !== 0 || uf !== 0) $display("FAIL wrap_next_shape: got bad=%0d uf=%0d required 0/0", bad, uf); else n_pass++;
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_reset_midframe();
    test_enable_drop_and_wrap_push();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
